// File: rtl/nibble_timer_ctrl.sv
// Programmable timer sequencing a cascaded pair of 4-bit nibble counters.
// Accepts limit/divisor/mode over valid/ready, pulses done at the terminal count.
module nibble_timer_ctrl #(
  parameter logic [7:0]  LIMIT_RST = 8'hFF,
  parameter int unsigned DIV_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_limit,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [3:0]       count1,
  output logic [3:0]       count2,
  output logic [7:0]       out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [7:0]         limit_q, limit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mode_q, mode_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [3:0]         count1_q, count1_d;
  logic [3:0]         count2_q, count2_d;
  logic [7:0]         out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         wrap_q, wrap_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               tick_c, term_c;

  assign tick_c = (pre_q == div_q);
  assign term_c = tick_c && ({count2_q, count1_q} == limit_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: stop beats any coincident terminal tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop)                 state_d = IDLE;
        else if (term_c && !mode_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    limit_d  = limit_q;
    div_d    = div_q;
    mode_d   = mode_q;
    pre_d    = pre_q;
    count1_d = count1_q;
    count2_d = count2_q;
    wrap_d   = wrap_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          limit_d = cfg_limit;
          div_d   = cfg_div;
          mode_d  = cfg_mode;
        end
        if (start) begin
          pre_d    = '0;
          count1_d = 4'd0;
          count2_d = 4'd0;
          wrap_d   = 8'd0;
        end
      end
      RUN: begin
        if (!stop) begin
          if (tick_c) begin
            pre_d = '0;
            if (term_c) begin
              count1_d = 4'd0;
              count2_d = 4'd0;
              done_d   = 1'b1;
              wrap_d   = wrap_q + 8'd1;
            end else if (count1_q != 4'hF) begin
              count1_d = count1_q + 4'd1;
            end else begin
              count1_d = 4'd0;
              count2_d = count2_q + 4'd1;
            end
          end else begin
            pre_d = pre_q + DIV_W'(1);
          end
        end
      end
      default: ;
    endcase
    out_d       = {count2_d, count1_d};
    busy_d      = (state_d == RUN);
    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q     <= LIMIT_RST;
      div_q       <= '0;
      mode_q      <= 1'b0;
      pre_q       <= '0;
      count1_q    <= 4'd0;
      count2_q    <= 4'd0;
      out_q       <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 8'd0;
      cfg_ready_q <= 1'b1;
    end else begin
      limit_q     <= limit_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pre_q       <= pre_d;
      count1_q    <= count1_d;
      count2_q    <= count2_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign count1    = count1_q;
  assign count2    = count2_q;
  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap_cnt  = wrap_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_nibble_timer_ctrl.sv
// Bench for nibble_timer_ctrl: an elapsed-cycle model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_nibble_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_limit = 8'h00;
  logic [3:0] cfg_div = 4'h0;
  logic       cfg_mode = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count1, count2;
  logic [7:0] out;
  logic       busy, done;
  logic [7:0] wrap_cnt;

  int n_checks = 0;
  int n_errors = 0;

  nibble_timer_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_limit(cfg_limit), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .start(start), .stop(stop), .count1(count1), .count2(count2),
    .out(out), .busy(busy), .done(done), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: position in a run is just the cycle count k since the start edge.
  bit m_valid = 0;
  bit m_run = 0;
  int m_k = 0, m_limit = 255, m_div = 0, m_mode = 0;
  int m_cnt = 0, m_wrap = 0, m_done = 0;

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_valid = 1; m_run = 0; m_k = 0; m_cnt = 0; m_wrap = 0; m_done = 0;
      m_limit = 255; m_div = 0; m_mode = 0;
    end else if (m_run) begin
      m_done = 0;
      if (stop) m_run = 0;
      else begin
        m_k++;
        p = (m_limit + 1) * (m_div + 1);
        m_cnt  = (m_k / (m_div + 1)) % (m_limit + 1);
        m_done = (m_k % p == 0) ? 1 : 0;
        m_wrap = (m_k / p) % 256;
        if (m_mode == 0 && m_k == p) m_run = 0;
      end
    end else begin
      m_done = 0;
      if (cfg_valid) begin
        m_limit = int'(cfg_limit); m_div = int'(cfg_div); m_mode = int'(cfg_mode);
      end
      if (start) begin
        m_run = 1; m_k = 0; m_cnt = 0; m_wrap = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_count1",    int'(count1),    m_cnt % 16);
      check("m_count2",    int'(count2),    m_cnt / 16);
      check("m_out",       int'(out),       m_cnt);
      check("m_busy",      int'(busy),      int'(m_run));
      check("m_cfg_ready", int'(cfg_ready), int'(!m_run));
      check("m_done",      int'(done),      m_done);
      check("m_wrap_cnt",  int'(wrap_cnt),  m_wrap);
    end
  end

  // Drive one cycle of inputs; the following posedge (E0) samples them.
  task automatic pulse(input bit st, input bit sp, input bit cv,
                       input logic [7:0] lim, input logic [3:0] dv, input bit md);
    @(posedge clk); #2;
    start = st; stop = sp; cfg_valid = cv; cfg_limit = lim; cfg_div = dv; cfg_mode = md;
    @(posedge clk); #2;
    start = 0; stop = 0; cfg_valid = 0;
  endtask

  // From E0+2, advance to the negedge following edge E(k) where k grows by n.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit_out(input string name, input int o, input int d, input int b);
    check({name, "_out"},  int'(out),  o);
    check({name, "_done"}, int'(done), d);
    check({name, "_busy"}, int'(busy), b);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    lit_out("rst", 0, 0, 0);
    check("rst_wrap", int'(wrap_cnt), 0);
    check("rst_ready", int'(cfg_ready), 1);

    // Default config: limit FF, d=0, one-shot -> done after E256
    pulse(1, 0, 0, 8'h00, 4'h0, 0);
    wait_edges(255); lit_out("dflt_e255", 8'hFF, 0, 1);
    wait_edges(1);   lit_out("dflt_e256", 8'h00, 1, 0);

    // One-shot L=5 d=0
    pulse(1, 0, 1, 8'h05, 4'h0, 0);
    wait_edges(5); lit_out("os_e5", 5, 0, 1);
    wait_edges(1); lit_out("os_e6", 0, 1, 0);
    check("os_ready", int'(cfg_ready), 1);
    check("os_wrap", int'(wrap_cnt), 1);
    wait_edges(1); check("os_done_clear", int'(done), 0);

    // Nibble carry L=0x20 d=0
    pulse(1, 0, 1, 8'h20, 4'h0, 0);
    wait_edges(15); lit_out("nc_e15", 8'h0F, 0, 1);
    wait_edges(1);  lit_out("nc_e16", 8'h10, 0, 1);
    wait_edges(16); lit_out("nc_e32", 8'h20, 0, 1);
    wait_edges(1);  lit_out("nc_e33", 8'h00, 1, 0);

    // Periodic L=2 d=2
    pulse(1, 0, 1, 8'h02, 4'h2, 1);
    wait_edges(2); check("per_e2", int'(out), 0);
    wait_edges(1); check("per_e3", int'(out), 1);
    wait_edges(6); lit_out("per_e9", 0, 1, 1);  check("per_w1", int'(wrap_cnt), 1);
    wait_edges(9); lit_out("per_e18", 0, 1, 1); check("per_w2", int'(wrap_cnt), 2);
    wait_edges(9); lit_out("per_e27", 0, 1, 1); check("per_w3", int'(wrap_cnt), 3);
    pulse(0, 1, 0, 8'h00, 4'h0, 0);
    @(negedge clk); check("per_stop_busy", int'(busy), 0);

    // Stop on E6 with L=5 d=0; cfg attempt during run is blocked
    pulse(1, 1, 1, 8'h05, 4'h0, 0);
    #0; // start beats coincident stop; now at E0+2
    @(posedge clk); #2;                // E1+2
    cfg_valid = 1; cfg_limit = 8'h33; cfg_div = 4'h7; cfg_mode = 1;
    @(negedge clk); check("blk_ready", int'(cfg_ready), 0);
    @(posedge clk); #2; cfg_valid = 0; // E2+2
    repeat (3) @(posedge clk); #2;     // E5+2
    stop = 1;
    @(posedge clk); #2; stop = 0;      // E6+2
    @(negedge clk); lit_out("stop_e6", 5, 0, 0);
    check("stop_wrap", int'(wrap_cnt), 0);
    // Limit still 5, d still 0, one-shot
    pulse(1, 0, 0, 8'h00, 4'h0, 0);
    wait_edges(6); lit_out("keep_e6", 0, 1, 0);

    // Zero limit, d=1, periodic: every tick terminal
    pulse(1, 0, 1, 8'h00, 4'h1, 1);
    wait_edges(2); lit_out("z_e2", 0, 1, 1);
    wait_edges(2); lit_out("z_e4", 0, 1, 1); check("z_wrap", int'(wrap_cnt), 2);
    pulse(0, 1, 0, 8'h00, 4'h0, 0);

    // Reset in mid periodic run at count 0x17
    pulse(1, 0, 1, 8'h20, 4'h0, 1);
    repeat (23) @(posedge clk);
    @(negedge clk); check("mr_pre", int'(out), 8'h17);
    #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk); lit_out("mr_rst", 0, 0, 0);
    check("mr_ready", int'(cfg_ready), 1);
    pulse(1, 0, 0, 8'h00, 4'h0, 0);
    wait_edges(255); lit_out("mr_e255", 8'hFF, 0, 1);
    wait_edges(1);   lit_out("mr_e256", 8'h00, 1, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
